// File: rtl/display_prefetch.sv
// display_prefetch: streams one frame of pixel words from SDRAM into a FIFO for the LCD stage.
// Define DISPLAY_PREFETCH_PATTERN_EN to add iPattern_En and the pixel-index test pattern.
module display_prefetch #(
    parameter int unsigned         H_ACTIVE        = 800,
    parameter int unsigned         V_ACTIVE        = 480,
    parameter int unsigned         FIFO_DEPTH      = 64,
    parameter int unsigned         ADDR_W          = 23,
    parameter logic [ADDR_W-1:0]   BASE_ADDR       = '0,
    parameter logic [31:0]         UNDERFLOW_COLOR = 32'h00FF00FF,
    localparam int unsigned        LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iNew_Frame,
    input  logic              iRead_Req,
`ifdef DISPLAY_PREFETCH_PATTERN_EN
    input  logic              iPattern_En,
`endif
    output logic [31:0]       oREAD_DATA,
    output logic [ADDR_W-1:0] oMem_Addr,
    output logic              oMem_Read,
    input  logic              iMem_Wait,
    input  logic [31:0]       iMem_Data,
    input  logic              iMem_Valid,
    output logic [LVL_W-1:0]  oFifo_Level,
    output logic              oUnderflow
);

    localparam int unsigned PTR_W = LVL_W - 1;
    localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam logic [LVL_W:0]   DEPTH_C = (LVL_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  req_q, req_d;
    // In DRAIN this counter is also the number of stale returns left to drop
    logic [LVL_W-1:0]  outst_q, outst_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [31:0]       data_q, data_d;
    logic              unf_q, unf_d;
    logic [31:0]       mem_q [FIFO_DEPTH];

`ifdef DISPLAY_PREFETCH_PATTERN_EN
    logic [23:0]       pix_q, pix_d;
`endif

    logic issue, accept, ret, push, pop, empty;

    always_comb begin
        empty  = (level_q == '0);
        issue  = (state_q == FETCH) && !iNew_Frame && (req_q < TOTAL_C)
                 && (({1'b0, level_q} + {1'b0, outst_q}) < DEPTH_C);
        accept = issue && !iMem_Wait;
        ret    = iMem_Valid && (outst_q != '0);
        push   = ret && !iNew_Frame && ((state_q == FETCH) || (state_q == DONE));
        pop    = iRead_Req && !iNew_Frame && !empty;
    end

    always_comb begin
        outst_d = outst_q;
        unique case ({accept, ret})
            2'b10:   outst_d = outst_q + LVL_W'(1);
            2'b01:   outst_d = outst_q - LVL_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = IDLE;
            FETCH:   if (accept && (req_q == LAST_C)) state_d = DONE;
            DONE:    state_d = DONE;
            DRAIN:   if (outst_d == '0) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        if (iNew_Frame) begin
            state_d = (outst_d != '0) ? DRAIN : FETCH;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        req_d   = req_q;
        level_d = level_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        data_d  = data_q;
        unf_d   = unf_q;
`ifdef DISPLAY_PREFETCH_PATTERN_EN
        pix_d   = pix_q;
`endif
        if (accept) begin
            addr_d = addr_q + ADDR_W'(1);
            req_d  = req_q + CNT_W'(1);
        end
        if (push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d   = rd_q + PTR_W'(1);
            data_d = mem_q[rd_q];
`ifdef DISPLAY_PREFETCH_PATTERN_EN
            if (iPattern_En) begin
                data_d = {8'h00, pix_q};
            end
            pix_d = pix_q + 24'd1;
`endif
        end else if (iRead_Req) begin
            data_d = UNDERFLOW_COLOR;
        end
        if (iRead_Req && empty && !iNew_Frame) begin
            unf_d = 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // A new frame flushes everything; a same-cycle pop still sees UNDERFLOW_COLOR
        if (iNew_Frame) begin
            addr_d  = BASE_ADDR;
            req_d   = '0;
            level_d = '0;
            wr_d    = '0;
            rd_d    = '0;
            unf_d   = 1'b0;
`ifdef DISPLAY_PREFETCH_PATTERN_EN
            pix_d   = '0;
`endif
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            req_q   <= '0;
            outst_q <= '0;
            level_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            unf_q   <= 1'b0;
`ifdef DISPLAY_PREFETCH_PATTERN_EN
            pix_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            outst_q <= outst_d;
            level_q <= level_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            unf_q   <= unf_d;
`ifdef DISPLAY_PREFETCH_PATTERN_EN
            pix_q   <= pix_d;
`endif
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) begin
            mem_q[wr_q] <= iMem_Data;
        end
    end

    assign oMem_Read   = issue;
    assign oMem_Addr   = addr_q;
    assign oREAD_DATA  = data_q;
    assign oFifo_Level = level_q;
    assign oUnderflow  = unf_q;

endmodule

// File: tb/tb_display_prefetch.sv
// Self-checking bench for display_prefetch: directed scenarios plus randomised traffic
// compared against a queue-based reference model of the frame prefetcher.
module tb_display_prefetch;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 23;
    localparam int TOTAL = H * V;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] UNDER = 32'h00FF00FF;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iNew_Frame = 1'b0;
    logic          iRead_Req = 1'b0;
    logic          iMem_Wait = 1'b0;
    logic          iMem_Valid = 1'b0;
    logic [31:0]   iMem_Data = '0;
    logic [31:0]   oREAD_DATA;
    logic [AW-1:0] oMem_Addr;
    logic          oMem_Read;
    logic [LW-1:0] oFifo_Level;
    logic          oUnderflow;

    always #5 iCLK = ~iCLK;

    display_prefetch #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH), .ADDR_W(AW),
        .BASE_ADDR(23'd0), .UNDERFLOW_COLOR(UNDER)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iNew_Frame(iNew_Frame), .iRead_Req(iRead_Req),
`ifdef DISPLAY_PREFETCH_PATTERN_EN
        .iPattern_En(1'b0),
`endif
        .oREAD_DATA(oREAD_DATA), .oMem_Addr(oMem_Addr), .oMem_Read(oMem_Read),
        .iMem_Wait(iMem_Wait), .iMem_Data(iMem_Data), .iMem_Valid(iMem_Valid),
        .oFifo_Level(oFifo_Level), .oUnderflow(oUnderflow)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // memory environment: memory[a] = a, in-order returns
    typedef struct { logic [AW-1:0] a; int due; } req_t;
    req_t pend[$];
    int   last_due = -1;
    int   lat_lo = 3;
    int   lat_hi = 3;
    bit   rand_wait = 1'b0;
    int   wait_addr = -1;
    int   wait_left = 0;
    logic [AW-1:0] acc_log[$];
    int   acc_cyc[$];
    int   ret_cyc[$];

    // reference model
    logic [31:0]   mq[$];
    int            m_outst, m_reqs, m_discard;
    bit            m_active, m_unf;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_data;

    bit            s_read, s_exp_read;
    logic [AW-1:0] s_addr, s_exp_addr;

    task automatic model_reset();
        mq.delete();
        m_outst = 0; m_reqs = 0; m_discard = 0;
        m_active = 0; m_unf = 0; m_addr = '0; m_data = '0;
    endtask

    // one clock cycle: inputs set by caller, memory reacts, model advances
    task automatic tick();
        int d;
        bit acc, ret;
        iMem_Wait = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            iMem_Valid = 1'b1;
            iMem_Data  = 32'(pend[0].a);
            void'(pend.pop_front());
            ret_cyc.push_back(cyc);
        end else begin
            iMem_Valid = 1'b0;
            iMem_Data  = $urandom;
        end
        #1;
        if (wait_left > 0 && oMem_Read && oMem_Addr == AW'(wait_addr)) begin
            iMem_Wait = 1'b1;
            wait_left--;
        end
        s_read     = oMem_Read;
        s_addr     = oMem_Addr;
        s_exp_read = m_active && !iRST && m_discard == 0 && m_reqs < TOTAL
                     && (mq.size() + m_outst < DEPTH) && !iNew_Frame;
        s_exp_addr = m_addr;
        if (oMem_Read && !iMem_Wait) begin
            d = cyc + int'($urandom_range(lat_lo, lat_hi)) - 1;
            if (d <= last_due) d = last_due + 1;
            pend.push_back('{oMem_Addr, d});
            last_due = d;
            acc_log.push_back(oMem_Addr);
            acc_cyc.push_back(cyc);
        end
        if (iRST) begin
            model_reset();
        end else begin
            acc = s_exp_read && !iMem_Wait;
            ret = iMem_Valid && m_outst > 0;
            if (iRead_Req) begin
                if (iNew_Frame || mq.size() == 0) begin
                    m_data = UNDER;
                    if (!iNew_Frame) m_unf = 1'b1;
                end else begin
                    m_data = mq.pop_front();
                end
            end
            if (ret) begin
                m_outst--;
                if (m_discard > 0) m_discard--;
                else if (m_active && !iNew_Frame) mq.push_back(iMem_Data);
            end
            if (acc) begin
                m_outst++; m_reqs++; m_addr++;
            end
            if (iNew_Frame) begin
                mq.delete();
                m_addr = '0; m_reqs = 0; m_unf = 1'b0; m_active = 1'b1;
                m_discard = m_outst;
            end
        end
        @(posedge iCLK);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        tests++; if (oREAD_DATA !== 32'h0) begin fails++;
            $display("FAIL reset_data: got %h expected 0", oREAD_DATA); end
        tests++; if (oMem_Read !== 1'b0) begin fails++;
            $display("FAIL reset_read: got %b expected 0", oMem_Read); end
        tests++; if (oMem_Addr !== AW'(0)) begin fails++;
            $display("FAIL reset_addr: got %h expected 0", oMem_Addr); end
        tests++; if (oFifo_Level !== LW'(0)) begin fails++;
            $display("FAIL reset_level: got %0d expected 0", oFifo_Level); end
        tests++; if (oUnderflow !== 1'b0) begin fails++;
            $display("FAIL reset_underflow: got %b expected 0", oUnderflow); end
        iRST = 1'b0;
        model_reset();
    endtask

    task automatic test_frame_fetch();
        acc_log.delete();
        iNew_Frame = 1'b1; tick(); iNew_Frame = 1'b0;
        repeat (12) tick();
        tests++; if (acc_log.size() != 4) begin fails++;
            $display("FAIL fetch_count: got %0d expected 4", acc_log.size()); end
        for (int i = 0; i < acc_log.size() && i < 4; i++) begin
            tests++; if (acc_log[i] !== AW'(i)) begin fails++;
                $display("FAIL fetch_addr[%0d]: got %0d expected %0d", i, acc_log[i], i); end
        end
        tests++; if (oMem_Read !== 1'b0) begin fails++;
            $display("FAIL fetch_read_idle: got %b expected 0", oMem_Read); end
        tests++; if (oFifo_Level !== LW'(4)) begin fails++;
            $display("FAIL fetch_level: got %0d expected 4", oFifo_Level); end
    endtask

    task automatic test_stream();
        iRead_Req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            tests++; if (oREAD_DATA !== 32'(k)) begin fails++;
                $display("FAIL stream_data[%0d]: got %h expected %h", k, oREAD_DATA, 32'(k)); end
            tests++; if (oUnderflow !== 1'b0) begin fails++;
                $display("FAIL stream_underflow[%0d]: got %b expected 0", k, oUnderflow); end
        end
        iRead_Req = 1'b0;
        repeat (6) tick();
        tests++; if (acc_log.size() != TOTAL) begin fails++;
            $display("FAIL stream_total: got %0d expected %0d", acc_log.size(), TOTAL); end
        for (int i = 4; i < acc_log.size(); i++) begin
            tests++; if (acc_log[i] !== AW'(i)) begin fails++;
                $display("FAIL stream_addr[%0d]: got %0d expected %0d", i, acc_log[i], i); end
        end
        tests++; if (oMem_Read !== 1'b0 || oFifo_Level !== LW'(0)) begin fails++;
            $display("FAIL stream_done: got read=%b level=%0d expected read=0 level=0",
                     oMem_Read, oFifo_Level); end
        tests++; if (oREAD_DATA !== 32'd7) begin fails++;
            $display("FAIL stream_hold: got %h expected 7", oREAD_DATA); end
    endtask

    task automatic test_wait_states();
        int held;
        held = 0;
        acc_log.delete();
        wait_addr = 2; wait_left = 5;
        iNew_Frame = 1'b1; tick(); iNew_Frame = 1'b0;
        repeat (16) begin
            tick();
            if (s_read && s_addr == AW'(2)) held++;
        end
        wait_left = 0;
        tests++; if (held != 6) begin fails++;
            $display("FAIL wait_hold: got %0d cycles expected 6", held); end
        tests++; if (acc_log.size() != 4) begin fails++;
            $display("FAIL wait_count: got %0d expected 4", acc_log.size()); end
        for (int i = 0; i < acc_log.size() && i < 4; i++) begin
            tests++; if (acc_log[i] !== AW'(i)) begin fails++;
                $display("FAIL wait_addr[%0d]: got %0d expected %0d", i, acc_log[i], i); end
        end
        iRead_Req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if (oREAD_DATA !== 32'(k)) begin fails++;
                $display("FAIL wait_data[%0d]: got %h expected %h", k, oREAD_DATA, 32'(k)); end
        end
        iRead_Req = 1'b0;
    endtask

    task automatic test_underflow();
        iNew_Frame = 1'b1; tick(); iNew_Frame = 1'b0;
        iRead_Req = 1'b1; tick(); iRead_Req = 1'b0;
        tests++; if (oREAD_DATA !== UNDER) begin fails++;
            $display("FAIL underflow_data: got %h expected %h", oREAD_DATA, UNDER); end
        tests++; if (oUnderflow !== 1'b1) begin fails++;
            $display("FAIL underflow_flag: got %b expected 1", oUnderflow); end
        repeat (3) tick();
        tests++; if (oUnderflow !== 1'b1) begin fails++;
            $display("FAIL underflow_sticky: got %b expected 1", oUnderflow); end
        iNew_Frame = 1'b1; tick(); iNew_Frame = 1'b0;
        tests++; if (oUnderflow !== 1'b0) begin fails++;
            $display("FAIL underflow_clear: got %b expected 0", oUnderflow); end
        iRead_Req = 1'b1; tick();
        iNew_Frame = 1'b1; tick(); iNew_Frame = 1'b0; iRead_Req = 1'b0;
        tests++; if (oREAD_DATA !== UNDER || oUnderflow !== 1'b0) begin fails++;
            $display("FAIL flush_pop: got data=%h flag=%b expected data=%h flag=0",
                     oREAD_DATA, oUnderflow, UNDER); end
        repeat (12) tick();
    endtask

    task automatic test_restart();
        lat_lo = 6; lat_hi = 6;
        acc_log.delete();
        iNew_Frame = 1'b1; tick(); iNew_Frame = 1'b0;
        repeat (3) tick();
        tests++; if (acc_log.size() != 3) begin fails++;
            $display("FAIL restart_pre: got %0d requests expected 3", acc_log.size()); end
        iNew_Frame = 1'b1; tick(); iNew_Frame = 1'b0;
        tests++; if (s_read !== 1'b0) begin fails++;
            $display("FAIL restart_read_drop: got %b expected 0", s_read); end
        acc_log.delete(); acc_cyc.delete(); ret_cyc.delete();
        repeat (12) begin
            tick();
            if (ret_cyc.size() < 3) begin
                tests++; if (oFifo_Level !== LW'(0)) begin fails++;
                    $display("FAIL restart_drain_level: got %0d expected 0", oFifo_Level); end
            end
        end
        tests++; if (ret_cyc.size() < 3 || acc_cyc.size() < 1 || acc_cyc[0] != ret_cyc[2] + 1) begin
            fails++;
            $display("FAIL restart_timing: got returns=%0d accepts=%0d expected request right after third return",
                     ret_cyc.size(), acc_cyc.size()); end
        tests++; if (acc_log.size() < 1 || acc_log[0] !== AW'(0)) begin fails++;
            $display("FAIL restart_addr: got %0d requests expected first at 0", acc_log.size()); end
        for (int i = 0; i < 20 && oFifo_Level == LW'(0); i++) tick();
        tests++; if (oFifo_Level === LW'(0)) begin fails++;
            $display("FAIL restart_timeout: got level 0 expected data to arrive"); end
        iRead_Req = 1'b1; tick(); iRead_Req = 1'b0;
        tests++; if (oREAD_DATA !== 32'h0) begin fails++;
            $display("FAIL restart_first_word: got %h expected 0", oREAD_DATA); end
        lat_lo = 3; lat_hi = 3;
        repeat (12) tick();
    endtask

    task automatic test_async_reset();
        iNew_Frame = 1'b1; tick(); iNew_Frame = 1'b0;
        iRead_Req = 1'b1; repeat (2) tick(); iRead_Req = 1'b0;
        iRST = 1'b1;
        #2;
        tests++; if (oREAD_DATA !== 32'h0 || oMem_Read !== 1'b0 || oMem_Addr !== AW'(0)
                     || oFifo_Level !== LW'(0) || oUnderflow !== 1'b0) begin fails++;
            $display("FAIL async_reset: got data=%h read=%b addr=%0d level=%0d unf=%b expected all 0",
                     oREAD_DATA, oMem_Read, oMem_Addr, oFifo_Level, oUnderflow); end
        tick();
        iRST = 1'b0;
        repeat (10) tick();
        tests++; if (oFifo_Level !== LW'(0) || oMem_Read !== 1'b0) begin fails++;
            $display("FAIL reset_ignore_returns: got level=%0d read=%b expected 0 0",
                     oFifo_Level, oMem_Read); end
    endtask

    task automatic test_random();
        int rr_pct;
        rr_pct = 50;
        rand_wait = 1'b1;
        lat_lo = 2; lat_hi = 6;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) rr_pct = 10 + 40 * int'($urandom_range(0, 2));
            iNew_Frame = ($urandom_range(0, 39) == 0);
            iRead_Req  = ($urandom_range(0, 99) < rr_pct);
            tick();
            tests++; if (s_read !== s_exp_read) begin fails++;
                $display("FAIL rand_read@%0d: got %b expected %b", cyc, s_read, s_exp_read); end
            if (s_read && s_exp_read) begin
                tests++; if (s_addr !== s_exp_addr) begin fails++;
                    $display("FAIL rand_addr@%0d: got %0d expected %0d", cyc, s_addr, s_exp_addr); end
            end
            tests++; if (oREAD_DATA !== m_data) begin fails++;
                $display("FAIL rand_data@%0d: got %h expected %h", cyc, oREAD_DATA, m_data); end
            tests++; if (oFifo_Level !== LW'(mq.size())) begin fails++;
                $display("FAIL rand_level@%0d: got %0d expected %0d", cyc, oFifo_Level, mq.size()); end
            tests++; if (oUnderflow !== m_unf) begin fails++;
                $display("FAIL rand_underflow@%0d: got %b expected %b", cyc, oUnderflow, m_unf); end
            tests++; if (oFifo_Level > LW'(DEPTH)) begin fails++;
                $display("FAIL rand_overflow@%0d: got level %0d expected <= %0d", cyc, oFifo_Level, DEPTH); end
        end
        iNew_Frame = 1'b0; iRead_Req = 1'b0;
        rand_wait = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge iCLK);
        #1;
        test_reset();
        test_frame_fetch();
        test_stream();
        test_wait_states();
        test_underflow();
        test_restart();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
